// File: rtl/serial_echo_engine_if.sv
// Byte-level handshake bundle between the echo engine, the rx byte source and the quick_rs232 transmitter.
// master = echo engine side, slave = UART/byte-source side.
interface serial_echo_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_byte_valid;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_err;
    logic                  tx_transaction;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_data_ready;
    logic                  tx_data_copied;
    logic                  tx_busy;

    modport master (
        input  rx_byte_valid, rx_byte, rx_err, tx_data_copied, tx_busy,
        output tx_transaction, tx_data, tx_data_ready
    );

    modport slave (
        output rx_byte_valid, rx_byte, rx_err, tx_data_copied, tx_busy,
        input  tx_transaction, tx_data, tx_data_ready
    );
endinterface

// File: rtl/serial_echo_engine.sv
// Echo engine: buffers received bytes in a FIFO, transforms them by mode at pop time and replays them
// through the quick_rs232 tx handshake, with drop statistics and pulse-stretched activity LEDs.
module serial_echo_engine #(
    parameter int                        DATA_WIDTH      = 8,
    parameter int                        FIFO_ADDR_WIDTH = 4,
    parameter int                        INC_VALUE       = 1,
    parameter logic [DATA_WIDTH-1:0]     XOR_MASK        = {DATA_WIDTH{1'b1}},
    parameter int                        TX_GAP_CYCLES   = 10,
    parameter int                        LED_HOLD_CYCLES = 10000000
) (
    input  logic                       clk,
    input  logic                       rst,
    serial_echo_engine_if.master       bus,
    input  logic [1:0]                 i_mode,
    output logic [FIFO_ADDR_WIDTH:0]   o_fifo_level,
    output logic [7:0]                 o_overflow_count,
    output logic [7:0]                 o_err_count,
    output logic                       o_rx_led,
    output logic                       o_tx_led
);
    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam int GAP_W = (TX_GAP_CYCLES > 1) ? $clog2(TX_GAP_CYCLES) : 1;
    localparam int LED_W = $clog2(LED_HOLD_CYCLES + 1);
    localparam logic [GAP_W-1:0]           GAP_LAST   = GAP_W'(TX_GAP_CYCLES - 1);
    localparam logic [LED_W-1:0]           LED_LOAD   = LED_W'(LED_HOLD_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0]      INC_T      = DATA_WIDTH'(INC_VALUE);
    localparam logic [FIFO_ADDR_WIDTH:0]   LEVEL_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP, S_DRAIN} state_t;

    function automatic logic [DATA_WIDTH-1:0] f_transform(input logic [DATA_WIDTH-1:0] b,
                                                          input logic [1:0] m);
        logic [DATA_WIDTH-1:0] rev;
        logic [DATA_WIDTH-1:0] res;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rev[i] = b[DATA_WIDTH-1-i];
        end
        case (m)
            2'd0:    res = b;
            2'd1:    res = b + INC_T;
            2'd2:    res = b ^ XOR_MASK;
            default: res = rev;
        endcase
        return res;
    endfunction

    state_t                     r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   r_level;
    logic [DATA_WIDTH-1:0]      r_tx_data, w_tx_data_nxt;
    logic                       r_tx_ready, w_tx_ready_nxt;
    logic                       r_tx_trans, w_tx_trans_nxt;
    logic [GAP_W-1:0]           r_gap_cnt, w_gap_cnt_nxt;
    logic [7:0]                 r_ovf_cnt, r_err_cnt;
    logic [LED_W-1:0]           r_rx_led_cnt, r_tx_led_cnt;
    logic                       r_rx_led, r_tx_led;
    logic                       w_pop, w_full, w_wr_ok, w_push, w_drop, w_tx_rise;

    assign w_full    = (r_level == LEVEL_FULL);
    assign w_wr_ok   = bus.rx_byte_valid & ~bus.rx_err;
    assign w_push    = w_wr_ok & (~w_full | w_pop);
    assign w_drop    = w_wr_ok & w_full & ~w_pop;
    assign w_tx_rise = w_tx_ready_nxt & ~r_tx_ready;

    // Next-state and next-output logic of the transmit sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_data_nxt  = r_tx_data;
        w_tx_ready_nxt = r_tx_ready;
        w_tx_trans_nxt = r_tx_trans;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop          = 1'b1;
                    w_tx_data_nxt  = f_transform(r_mem[r_rd_ptr], i_mode);
                    w_tx_ready_nxt = 1'b1;
                    w_tx_trans_nxt = 1'b1;
                    w_state_nxt    = S_LOAD;
                end else begin
                    w_state_nxt    = S_IDLE;
                end
            end
            S_LOAD: begin
                if (bus.tx_data_copied) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = S_GAP;
                end else begin
                    w_state_nxt   = S_LOAD;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_tx_ready_nxt = 1'b0;
                    w_state_nxt    = S_DRAIN;
                end else begin
                    w_gap_cnt_nxt  = r_gap_cnt + GAP_W'(1);
                end
            end
            S_DRAIN: begin
                if (!bus.tx_busy) begin
                    w_tx_trans_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_state_nxt    = S_DRAIN;
                end
            end
            default: begin
                w_tx_ready_nxt = 1'b0;
                w_tx_trans_nxt = 1'b0;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered tx handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx_data  <= '0;
            r_tx_ready <= 1'b0;
            r_tx_trans <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_tx_trans <= w_tx_trans_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

    // FIFO storage; contents are don't-care while the level is zero, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_byte;
        end
    end

    // FIFO pointers, occupancy and saturating drop statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_ovf_cnt <= 8'd0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_ADDR_WIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_ADDR_WIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (FIFO_ADDR_WIDTH + 1)'(1);
                2'b01:   r_level <= r_level - (FIFO_ADDR_WIDTH + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
            if (bus.rx_byte_valid && bus.rx_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Activity LED stretchers; a new event reloads the hold count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_led_cnt <= '0;
            r_tx_led_cnt <= '0;
            r_rx_led     <= 1'b1;
            r_tx_led     <= 1'b1;
        end else begin
            if (bus.rx_byte_valid) begin
                r_rx_led_cnt <= LED_LOAD;
                r_rx_led     <= 1'b0;
            end else if (r_rx_led_cnt != '0) begin
                r_rx_led_cnt <= r_rx_led_cnt - LED_W'(1);
                r_rx_led     <= 1'b0;
            end else begin
                r_rx_led     <= 1'b1;
            end
            if (w_tx_rise) begin
                r_tx_led_cnt <= LED_LOAD;
                r_tx_led     <= 1'b0;
            end else if (r_tx_led_cnt != '0) begin
                r_tx_led_cnt <= r_tx_led_cnt - LED_W'(1);
                r_tx_led     <= 1'b0;
            end else begin
                r_tx_led     <= 1'b1;
            end
        end
    end

    assign bus.tx_data        = r_tx_data;
    assign bus.tx_data_ready  = r_tx_ready;
    assign bus.tx_transaction = r_tx_trans;
    assign o_fifo_level       = r_level;
    assign o_overflow_count   = r_ovf_cnt;
    assign o_err_count        = r_err_cnt;
    assign o_rx_led           = r_rx_led;
    assign o_tx_led           = r_tx_led;
endmodule

// File: tb/tb_serial_echo_engine.sv
// Directed bench for serial_echo_engine: table of single-byte echoes plus hand-written
// sequences for handshake timing, overflow, rx errors, LED hold and reset mid-send.
module tb_serial_echo_engine;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int GAP  = 10;
    localparam int HOLD = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [AW:0]   level;
    logic [7:0]    ovf;
    logic [7:0]    errc;
    logic          rx_led;
    logic          tx_led;

    always #5 clk = ~clk;

    serial_echo_engine_if #(.DATA_WIDTH(DW)) bus ();

    serial_echo_engine #(
        .DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW), .INC_VALUE(1), .XOR_MASK(8'hFF),
        .TX_GAP_CYCLES(GAP), .LED_HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .i_mode(mode),
        .o_fifo_level(level), .o_overflow_count(ovf), .o_err_count(errc),
        .o_rx_led(rx_led), .o_tx_led(tx_led)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs [9];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic strobe(input logic [7:0] b, input logic e);
        bus.rx_byte       = b;
        bus.rx_err        = e;
        bus.rx_byte_valid = 1'b1;
        @(negedge clk);
        bus.rx_byte_valid = 1'b0;
        bus.rx_err        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.tx_data_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.tx_data_ready !== 1'b1) timeout(name);
    endtask

    // Completes one UART send starting from LOAD and returns in IDLE.
    task automatic finish_tx(input string name);
        int n = 0;
        bus.tx_data_copied = 1'b1;
        bus.tx_busy        = 1'b1;
        @(negedge clk);
        bus.tx_data_copied = 1'b0;
        while (bus.tx_data_ready !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.tx_data_ready !== 1'b0) timeout({name, "_ready_drop"});
        bus.tx_busy = 1'b0;
        @(negedge clk);
        if (bus.tx_transaction !== 1'b0) timeout({name, "_trans_drop"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int held;
        int seen;
        logic [7:0] exp_b;

        vecs[0] = '{2'd1, 8'h41, 8'h42};
        vecs[1] = '{2'd1, 8'hFF, 8'h00};
        vecs[2] = '{2'd2, 8'h81, 8'h7E};
        vecs[3] = '{2'd3, 8'h01, 8'h80};
        vecs[4] = '{2'd0, 8'h5A, 8'h5A};
        vecs[5] = '{2'd2, 8'h01, 8'hFE};
        vecs[6] = '{2'd3, 8'h81, 8'h81};
        vecs[7] = '{2'd3, 8'h12, 8'h48};
        vecs[8] = '{2'd2, 8'h00, 8'hFF};

        rst = 1'b1;
        mode = 2'd0;
        bus.rx_byte_valid  = 1'b0;
        bus.rx_byte        = 8'h00;
        bus.rx_err         = 1'b0;
        bus.tx_data_copied = 1'b0;
        bus.tx_busy        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.tx_data_ready, 0);
        check("rst_trans", bus.tx_transaction, 0);
        check("rst_data", bus.tx_data, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", errc, 0);
        check("rst_leds", {rx_led, tx_led}, 2'b11);
        rst = 1'b0;
        @(negedge clk);

        // Table: latency edge N+1 and transform result per mode.
        for (int i = 0; i < 9; i++) begin
            mode = vecs[i].mode;
            strobe(vecs[i].din, 1'b0);
            check($sformatf("vec%0d_not_yet", i), {bus.tx_data_ready, level}, {1'b0, 5'd1});
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {bus.tx_data_ready, bus.tx_transaction, level}, {2'b11, 5'd0});
            check($sformatf("vec%0d_data", i), bus.tx_data, vecs[i].dout);
            finish_tx($sformatf("vec%0d", i));
        end

        // Handshake: copied arrives 5 cycles late, ready held GAP cycles after it.
        do_reset();
        mode = 2'd0;
        strobe(8'h3C, 1'b0);
        @(negedge clk);
        check("hs_tx_led", tx_led, 0);
        repeat (5) @(negedge clk);
        check("hs_hold_load", {bus.tx_data_ready, bus.tx_data}, {1'b1, 8'h3C});
        bus.tx_data_copied = 1'b1;
        bus.tx_busy        = 1'b1;
        @(negedge clk);
        bus.tx_data_copied = 1'b0;
        held = 0;
        for (int j = 0; j < GAP; j++) begin
            if (bus.tx_data_ready === 1'b1) held++;
            @(negedge clk);
        end
        check("hs_gap_hold", held, GAP);
        check("hs_gap_drop", {bus.tx_data_ready, bus.tx_transaction}, 2'b01);
        repeat (3) @(negedge clk);
        check("hs_drain_busy", bus.tx_transaction, 1);
        bus.tx_busy = 1'b0;
        @(negedge clk);
        check("hs_trans_drop", bus.tx_transaction, 0);

        // Mode change while a byte is queued: the pop-time mode applies.
        mode = 2'd0;
        strobe(8'h55, 1'b0);
        @(negedge clk);
        check("msw_first", bus.tx_data, 8'h55);
        strobe(8'h81, 1'b0);
        mode = 2'd2;
        finish_tx("msw_first");
        wait_ready("msw_second");
        check("msw_second", bus.tx_data, 8'h7E);
        finish_tx("msw_second");

        // Overflow: 20 strobes with the handshake held off.
        do_reset();
        mode = 2'd0;
        for (int i = 0; i < 20; i++) strobe(8'h10 + 8'(i), 1'b0);
        check("ovf_level", level, 16);
        check("ovf_count", ovf, 3);
        check("ovf_first", {bus.tx_data_ready, bus.tx_data}, {1'b1, 8'h10});
        finish_tx("ovf_first");
        strobe(8'hAA, 1'b0);
        check("ovf_full_pop", {level, ovf}, {5'd16, 8'd3});
        for (int k = 0; k < 17; k++) begin
            exp_b = (k < 16) ? 8'h11 + 8'(k) : 8'hAA;
            wait_ready($sformatf("ovf_echo%0d", k));
            check($sformatf("ovf_echo%0d", k), bus.tx_data, exp_b);
            finish_tx($sformatf("ovf_echo%0d", k));
        end
        check("ovf_empty", level, 0);

        // rx error: no write, err_count, rx_led low for exactly HOLD cycles.
        do_reset();
        strobe(8'h77, 1'b1);
        check("err_level", level, 0);
        check("err_count", errc, 1);
        check("err_led_on", rx_led, 0);
        seen = 0;
        for (int j = 0; j < HOLD - 1; j++) begin
            @(negedge clk);
            if (bus.tx_data_ready !== 1'b0) seen++;
        end
        check("err_led_still", rx_led, 0);
        check("err_no_tx", seen, 0);
        @(negedge clk);
        check("err_led_off", rx_led, 1);

        // Reset while in GAP with 3 bytes queued.
        do_reset();
        mode = 2'd0;
        strobe(8'h01, 1'b0);
        strobe(8'h02, 1'b0);
        strobe(8'h03, 1'b0);
        strobe(8'h04, 1'b0);
        check("rstg_queued", level, 3);
        bus.tx_data_copied = 1'b1;
        bus.tx_busy        = 1'b1;
        @(negedge clk);
        bus.tx_data_copied = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstg_outputs", {bus.tx_data_ready, bus.tx_transaction, bus.tx_data}, 10'd0);
        check("rstg_level", level, 0);
        check("rstg_leds", {rx_led, tx_led}, 2'b11);
        rst = 1'b0;
        bus.tx_busy = 1'b0;
        seen = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (bus.tx_data_ready !== 1'b0 || bus.tx_transaction !== 1'b0) seen++;
        end
        check("rstg_no_tx", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
